spi_frame_tx: RTL and testbench
===============================

SPI_FRAME_TX -- requirements
Module: spi_frame_tx

Interface
REQ-001 Parameter CLK_DIV, default 5, gives the clk cycles per sck half-period; legal range 2..255.
REQ-002 Parameter SYNC_WORD, default 16'hAA55, is the 16-bit header prepended to every frame.
REQ-003 Parameter CS_IDLE, default 10, gives the minimum clk cycles cs stays high between frames; legal range 1..255.
REQ-004 Port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: frame request; accepted only in IDLE.
REQ-007 Port abort, input, 1 bit: synchronous frame cancel.
REQ-008 Port frame_data, input, 320 bits: payload, as 5 ADC words [319:240], then 15 coefficient words [239:0], each word MSB-first.
REQ-009 Port sck, output, 1 bit: SPI clock, mode 0, idle low.
REQ-010 Port sdo, output, 1 bit: serial data, MSB first.
REQ-011 Port cs, output, 1 bit: active-low chip select.
REQ-012 Port busy, output, 1 bit: high from the accept cycle until return to IDLE.
REQ-013 Port done, output, 1 bit: one-cycle pulse on completion of a frame.
REQ-014 Port frames_sent, output, 16 bits: count of completed frames.

Function
REQ-015 The block SHALL implement the FSM states IDLE, SETUP, SHIFT and GAP.
REQ-016 In IDLE: cs=1, sck=0, sdo=0, busy=0.
REQ-017 In IDLE with start=1, the block SHALL latch {SYNC_WORD, frame_data} (336 bits) into a shift register and enter SETUP; cs=0, busy=1 and sdo=bit 335 take effect on the next cycle.
REQ-018 frame_data SHALL be sampled only in the accept cycle; later changes to it do not affect the frame in flight.
REQ-019 SETUP SHALL hold sck=0 for CLK_DIV cycles, then enter SHIFT.
REQ-020 SHIFT SHALL run 336 sck periods, each CLK_DIV cycles high then CLK_DIV cycles low.
REQ-021 sdo SHALL change only coincident with a sck falling edge, and SHALL be stable across each rising edge.
REQ-022 Bit n, counted from 335 down to 0, SHALL be valid at rising edge 336-n.
REQ-023 A 9-bit bit counter SHALL terminate SHIFT after the low phase that follows the 336th rising edge.
REQ-024 On that SHIFT exit cycle: cs=1, sck=0, sdo=0, done=1 for exactly one cycle, frames_sent increments, and the state becomes GAP.
REQ-025 cs low duration SHALL be exactly 673*CLK_DIV clk cycles (3365 at default).
REQ-026 GAP SHALL hold cs=1 and busy=1 for CS_IDLE cycles, then enter IDLE.
REQ-027 start SHALL be ignored in SETUP, SHIFT and GAP; it is not queued.
REQ-028 start arriving in the first IDLE cycle SHALL be accepted normally.
REQ-029 abort=1 in SETUP or SHIFT SHALL, on the next cycle, force cs=1, sck=0, sdo=0 and enter GAP, with no done pulse and no increment of frames_sent.
REQ-030 abort in IDLE or GAP SHALL have no effect.
REQ-031 If start and abort are both 1 in IDLE, start SHALL be accepted.
REQ-032 frames_sent SHALL wrap from 16'hFFFF to 16'h0000.
REQ-033 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-034 While reset=0, asynchronously: state=IDLE, cs=1, sck=0, sdo=0, busy=0, done=0, frames_sent=0, and the shift register and counters are cleared.
REQ-035 Reset asserted mid-frame SHALL abandon the frame with no done pulse; after release, the block accepts start on the first clk edge.

Verification
REQ-036 Default frame: frame_data = ADC 0, low={4000,0,0,0,0}, mid and high the same -> a receiver model sampling on sck rise captures AA55 followed by the identical 320 bits; done pulses once; frames_sent=1.
REQ-037 Pattern frame: coefficients 1234,5678,9ABC,DEF0,1111,...,BBBB and frame_data changed one cycle after start -> captured data equals the original pattern; cs low measures 3365 cycles; sdo never changes while sck is high.
REQ-038 Abort at rising edge 100 -> cs high on the next cycle; no done; frames_sent unchanged; a following frame CAFE,BABE,... captures correctly.
REQ-039 start held high continuously for 3 frames -> frames separated by exactly CS_IDLE+1 cs-high cycles; frames_sent=3; exactly 3 done pulses.
REQ-040 reset pulsed low mid-SHIFT -> all outputs immediately take reset values, with no done pulse and frames_sent=0.
REQ-041 Force frames_sent to FFFF, then send 1 frame -> frames_sent=0000 and done=1.

Source files
------------

// File: rtl/spi_frame_tx.sv
// spi_frame_tx: SPI mode-0 transmitter sending {SYNC_WORD, 320-bit payload} frames MSB-first
module spi_frame_tx #(
  parameter int          CLK_DIV   = 5,
  parameter logic [15:0] SYNC_WORD = 16'hAA55,
  parameter int          CS_IDLE   = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [319:0] frame_data,
  output logic         sck,
  output logic         sdo,
  output logic         cs,
  output logic         busy,
  output logic         done,
  output logic [15:0]  frames_sent
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_IDLE - 1);
  localparam logic [8:0] NBITS    = 9'd336;

  logic [1:0]   state_q, state_d;
  logic [7:0]   div_q, div_d;
  logic [8:0]   bit_q, bit_d;
  logic [335:0] sr_q, sr_d;
  logic         sck_q, sck_d, cs_q, cs_d, busy_q, busy_d, done_q, done_d;
  logic [15:0]  frames_sent_q, frames_sent_d;
  logic         div_end;

  // div_q times the current sck half-period (or the gap length in GAP)
  assign div_end = div_q == (state_q == GAP ? GAP_LAST : DIV_LAST);

  // Next state: bit_q counts sck rising edges; sdo is the shift register MSB, zero-filled
  always_comb begin
    state_d       = state_q;
    div_d         = (div_end || state_q == IDLE) ? 8'd0 : div_q + 8'd1;
    bit_d         = bit_q;
    sr_d          = sr_q;
    sck_d         = sck_q;
    cs_d          = cs_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    frames_sent_d = frames_sent_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETUP;
        sr_d    = {SYNC_WORD, frame_data};
        cs_d    = 1'b0;
        busy_d  = 1'b1;
        bit_d   = 9'd0;
      end
      SETUP, SHIFT: if (abort) begin
        state_d = GAP;
        div_d   = 8'd0;
        sr_d    = '0;
        cs_d    = 1'b1;
        sck_d   = 1'b0;
      end else if (div_end) begin
        if (!sck_q) begin
          if (bit_q == NBITS) begin
            state_d       = GAP;
            cs_d          = 1'b1;
            done_d        = 1'b1;
            frames_sent_d = frames_sent_q + 16'd1;
          end else begin
            state_d = SHIFT;
            sck_d   = 1'b1;
            bit_d   = bit_q + 9'd1;
          end
        end else begin
          sck_d = 1'b0;
          sr_d  = {sr_q[334:0], 1'b0};
        end
      end
      default: if (div_end) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      div_q         <= '0;
      bit_q         <= '0;
      sr_q          <= '0;
      sck_q         <= 1'b0;
      cs_q          <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      frames_sent_q <= '0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      bit_q         <= bit_d;
      sr_q          <= sr_d;
      sck_q         <= sck_d;
      cs_q          <= cs_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      frames_sent_q <= frames_sent_d;
    end
  end

  assign sck         = sck_q;
  assign sdo         = sr_q[335];
  assign cs          = cs_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frames_sent = frames_sent_q;
endmodule

// File: tb/tb_spi_frame_tx.sv
// tb_spi_frame_tx: randomized bench checking spi_frame_tx against a cycle-offset frame model
module tb_spi_frame_tx;
  localparam int D  = 5;
  localparam int CI = 10;
  localparam int FL = 673 * D;

  logic         clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic [319:0] frame_data = '0;
  logic         sck, sdo, cs, busy, done;
  logic [15:0]  frames_sent;
  int           checks = 0, errors = 0;

  spi_frame_tx dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .frame_data(frame_data),
    .sck(sck), .sdo(sdo), .cs(cs), .busy(busy), .done(done), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  // model: mode 0 idle, 1 cs low (m_off cycles since accept), 2 gap (m_g cycles in)
  int           m_mode = 0, m_off = 0, m_g = 0;
  logic         m_done = 1'b0, preset = 1'b0;
  logic [15:0]  m_cnt = '0;
  logic [335:0] m_bits = '0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_mode = 0; m_done = 1'b0; m_cnt = '0;
    end else begin
      m_done = 1'b0;
      if (preset) m_cnt = 16'hFFFF;
      case (m_mode)
        0: if (start) begin m_mode = 1; m_off = 0; m_bits = {16'hAA55, frame_data}; end
        1: if (abort) begin m_mode = 2; m_g = 0; end
           else if (m_off == FL - 1) begin m_mode = 2; m_g = 0; m_done = 1'b1; m_cnt = m_cnt + 16'd1; end
           else m_off++;
        default: if (m_g == CI - 1) m_mode = 0; else m_g++;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // receiver state, updated by the compare process
  logic         prev_sck = 1'b0, prev_cs = 1'b1;
  logic [335:0] rx = '0, last_rx = '0;
  int           nrx = 0, last_nrx = 0, lowlen = 0, last_low = 0, highlen = 0, last_high = 0, dones = 0;

  // compare process: expected outputs from frame offset arithmetic, plus a sck-rise receiver
  initial forever begin
    logic e_cs, e_sck, e_sdo;
    int p, h, idx;
    @(negedge clk);
    e_cs = 1'b1; e_sck = 1'b0; e_sdo = 1'b0;
    if (m_mode == 1) begin
      e_cs = 1'b0;
      if (m_off < D) e_sdo = m_bits[335];
      else begin
        p = (m_off - D) / (2 * D);
        h = (m_off - D) % (2 * D);
        e_sck = h < D;
        idx = (h < D) ? 335 - p : 334 - p;
        e_sdo = (idx >= 0) ? m_bits[idx] : 1'b0;
      end
    end
    chk("cycle {cs,sck,sdo,busy,done,cnt}", {cs, sck, sdo, busy, done, frames_sent},
        {e_cs, e_sck, e_sdo, m_mode != 0, m_done, preset ? 16'hFFFF : m_cnt});
    if (!cs) begin
      if (prev_cs) begin last_high = highlen; lowlen = 0; nrx = 0; end
      lowlen++;
    end else begin
      if (!prev_cs) begin last_low = lowlen; last_rx = rx; last_nrx = nrx; highlen = 0; end
      highlen++;
    end
    if (!prev_sck && sck) begin rx = {rx[334:0], sdo}; nrx++; end
    if (done) dones++;
    prev_sck = sck; prev_cs = cs;
  end

  function automatic logic [319:0] pack(input logic [15:0] w [20]);
    logic [319:0] f;
    for (int i = 0; i < 20; i++) f[319 - 16 * i -: 16] = w[i];
    return f;
  endfunction

  function automatic logic [319:0] rnd_fd();
    logic [319:0] f;
    for (int i = 0; i < 10; i++) f[32 * i +: 32] = $urandom;
    return f;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic send(input logic [319:0] fd);
    frame_data = fd; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idle();
    @(negedge clk); #1;
  endtask

  task automatic chk_frame(input string name, input logic [319:0] fd);
    checks++;
    if (last_rx !== {16'hAA55, fd}) begin
      errors++;
      $display("FAIL %s_rx: got %h expected %h", name, last_rx, {16'hAA55, fd});
    end
    chk({name, "_bits"}, last_nrx, 336);
    chk({name, "_cs_low"}, last_low, 3365);
  endtask

  initial begin
    logic [15:0]  w [20];
    logic [319:0] fd;
    int           n, d0;
    // reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {cs, sck, sdo, busy, done}, 5'b10000);
    chk("reset_count", frames_sent, 16'h0000);
    // default frame, start on the first edge after reset release
    for (int i = 0; i < 20; i++) w[i] = 16'h0000;
    w[5] = 16'h4000; w[10] = 16'h4000; w[15] = 16'h4000;
    fd = pack(w);
    reset = 1'b1;
    send(fd);
    chk_frame("default", fd);
    chk("default_done", dones, 1);
    chk("default_count", frames_sent, 16'd1);
    // pattern frame with frame_data disturbed after acceptance
    for (int i = 0; i < 5; i++) w[i] = 16'(16'h0100 * (i + 1));
    w[5] = 16'h1234; w[6] = 16'h5678; w[7] = 16'h9ABC; w[8] = 16'hDEF0;
    for (int i = 0; i < 11; i++) w[9 + i] = 16'(16'h1111 * (i + 1));
    fd = pack(w);
    frame_data = fd; start = 1'b1;
    @(negedge clk); start = 1'b0; frame_data = ~fd;
    wait_idle();
    @(negedge clk); #1;
    chk_frame("pattern", fd);
    chk("pattern_count", frames_sent, 16'd2);
    // abort right after rising edge 100
    d0 = dones;
    frame_data = rnd_fd(); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (nrx < 100 && n < 2000) begin @(negedge clk); #1; n++; end
    chk("abort_reach_rise100", nrx, 100);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_cs_high", cs, 1'b1);
    wait_idle();
    chk("abort_no_done", dones, d0);
    chk("abort_count", frames_sent, 16'd2);
    // follow-up frame after abort
    w[0] = 16'hCAFE; w[1] = 16'hBABE;
    fd = pack(w);
    send(fd);
    chk_frame("cafe", fd);
    chk("cafe_count", frames_sent, 16'd3);
    // start held high across three frames
    d0 = dones;
    fd = rnd_fd();
    frame_data = fd; start = 1'b1;
    n = 0;
    while (dones < d0 + 3 && n < 15000) begin @(negedge clk); #1; n++; end
    start = 1'b0;
    wait_idle();
    chk("held_dones", dones - d0, 3);
    chk("held_cs_gap", last_high, CI + 1);
    chk("held_count", frames_sent, 16'd6);
    chk_frame("held", fd);
    // random start/abort/frame_data traffic, checked cycle by cycle
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      start = $urandom_range(0, 59) == 0;
      abort = $urandom_range(0, 1499) == 0;
      frame_data = rnd_fd();
    end
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    wait_idle();
    // reset mid-shift
    d0 = dones;
    frame_data = rnd_fd(); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (1000) @(negedge clk);
    @(posedge clk); #2; reset = 1'b0; #1;
    chk("midreset_outputs", {cs, sck, sdo, busy, done}, 5'b10000);
    chk("midreset_count", frames_sent, 16'h0000);
    repeat (3) @(negedge clk);
    chk("midreset_no_done", dones, d0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    // counter wrap
    @(posedge clk); #2;
    force dut.frames_sent_q = 16'hFFFF; preset = 1'b1;
    @(posedge clk); #2;
    release dut.frames_sent_q; preset = 1'b0;
    @(negedge clk);
    chk("wrap_preset", frames_sent, 16'hFFFF);
    d0 = dones;
    fd = rnd_fd();
    send(fd);
    chk_frame("wrap", fd);
    chk("wrap_done", dones - d0, 1);
    chk("wrap_count", frames_sent, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
